// File: rtl/game_event_ctrl.sv
// Game event controller: debounces the player buttons, runs the game FSM and
// drives the START/HURT/OVER/RESTART controls, the lives count and the invulnerability flag.
module game_event_ctrl #(
    parameter int LIVES           = 3,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int HURT_HOLD       = 4,
    parameter int INVULN_CYCLES   = 67108864
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       BTN_START,
    input  logic       BTN_RESTART,
    input  logic       COLLIDE,
    output logic       START,
    output logic       HURT,
    output logic       OVER,
    output logic       RESTART,
    output logic [3:0] LIVES_LEFT,
    output logic       INVULN
);

    localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int TMR_W  = (INVULN_CYCLES > 1)   ? $clog2(INVULN_CYCLES)   : 1;
    localparam int HOLD_W = (HURT_HOLD > 1)       ? $clog2(HURT_HOLD)       : 1;

    localparam logic [DB_W-1:0]   DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TMR_W-1:0]  TMR_LOAD   = TMR_W'(INVULN_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD  = HOLD_W'(HURT_HOLD - 1);
    localparam logic [3:0]        LIVES_INIT = 4'(LIVES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUNNING,
        ST_INVULN,
        ST_DEAD
    } state_t;

    // Index 0 is the start button, index 1 the restart button.
    logic [1:0]      btn_raw;
    logic [1:0]      sync_a;
    logic [1:0]      sync_b;
    logic [1:0]      db_level;
    logic [1:0]      db_level_q;
    logic [1:0]      press;
    logic [DB_W-1:0] db_cnt [2];

    logic start_press;
    logic restart_press;

    state_t state;
    state_t state_next;

    logic              hit;
    logic              hit_nonfatal;
    logic [TMR_W-1:0]  invuln_tmr;
    logic [HOLD_W-1:0] hurt_left;

    logic start_d;
    logic over_d;
    logic invuln_d;
    logic restart_d;

    assign btn_raw       = {BTN_RESTART, BTN_START};
    assign start_press   = press[0];
    assign restart_press = press[1];

    always_ff @(posedge CLK) begin
        if (RESET) begin
            sync_a     <= '0;
            sync_b     <= '0;
            db_level   <= '0;
            db_level_q <= '0;
            press      <= '0;
            for (int unsigned i = 0; i < 2; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync_a     <= btn_raw;
            sync_b     <= sync_a;
            db_level_q <= db_level;
            press      <= db_level & ~db_level_q;
            // The level flips on the DEBOUNCE_CYCLES-th consecutive disagreeing cycle.
            for (int unsigned i = 0; i < 2; i++) begin
                if (sync_b[i] == db_level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db_level[i] <= ~db_level[i];
                    db_cnt[i]   <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign hit          = (state == ST_RUNNING) && COLLIDE;
    assign hit_nonfatal = hit && (LIVES_LEFT > 4'd1);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start_press) begin
                    state_next = ST_RUNNING;
                end
            end
            ST_RUNNING: begin
                if (hit_nonfatal) begin
                    state_next = ST_INVULN;
                end else if (hit) begin
                    state_next = ST_DEAD;
                end
            end
            ST_INVULN: begin
                if (invuln_tmr == '0) begin
                    state_next = ST_RUNNING;
                end
            end
            ST_DEAD: begin
                if (restart_press) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Level outputs follow the upcoming state so they change on the transition edge.
    always_comb begin
        start_d   = (state_next == ST_RUNNING) || (state_next == ST_INVULN);
        over_d    = (state_next == ST_DEAD);
        invuln_d  = (state_next == ST_INVULN);
        restart_d = (state == ST_DEAD) && restart_press;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            START   <= 1'b0;
            OVER    <= 1'b0;
            INVULN  <= 1'b0;
            RESTART <= 1'b0;
        end else begin
            START   <= start_d;
            OVER    <= over_d;
            INVULN  <= invuln_d;
            RESTART <= restart_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            LIVES_LEFT <= '0;
            invuln_tmr <= '0;
            HURT       <= 1'b0;
            hurt_left  <= '0;
        end else begin
            if ((state == ST_IDLE) && start_press) begin
                LIVES_LEFT <= LIVES_INIT;
            end else if (hit_nonfatal) begin
                LIVES_LEFT <= LIVES_LEFT - 4'd1;
            end else if (hit) begin
                LIVES_LEFT <= '0;
            end

            if (hit_nonfatal) begin
                invuln_tmr <= TMR_LOAD;
            end else if ((state == ST_INVULN) && (invuln_tmr != '0)) begin
                invuln_tmr <= invuln_tmr - 1'b1;
            end

            // The pulse runs to completion regardless of later state changes.
            if (hit_nonfatal) begin
                HURT      <= 1'b1;
                hurt_left <= HOLD_LOAD;
            end else if (HURT) begin
                if (hurt_left == '0) begin
                    HURT <= 1'b0;
                end else begin
                    hurt_left <= hurt_left - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_game_event_ctrl.sv
// Directed, table-driven bench for game_event_ctrl with short debounce and
// invulnerability windows; expected outputs are hand-derived per cycle.
module tb_game_event_ctrl;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       BTN_START;
    logic       BTN_RESTART;
    logic       COLLIDE;
    logic       START;
    logic       HURT;
    logic       OVER;
    logic       RESTART;
    logic [3:0] LIVES_LEFT;
    logic       INVULN;

    game_event_ctrl #(
        .LIVES          (3),
        .DEBOUNCE_CYCLES(4),
        .HURT_HOLD      (4),
        .INVULN_CYCLES  (16)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .BTN_START  (BTN_START),
        .BTN_RESTART(BTN_RESTART),
        .COLLIDE    (COLLIDE),
        .START      (START),
        .HURT       (HURT),
        .OVER       (OVER),
        .RESTART    (RESTART),
        .LIVES_LEFT (LIVES_LEFT),
        .INVULN     (INVULN)
    );

    always #5 CLK = ~CLK;

    // exp = {START, HURT, OVER, RESTART, LIVES_LEFT[3:0], INVULN}
    typedef struct {
        string      name;
        int         n;
        logic       rst;
        logic       bs;
        logic       br;
        logic       col;
        logic [8:0] exp;
    } vec_t;

    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(string name, int n, logic rst, logic bs, logic br, logic col,
                                logic s, logic h, logic o, logic r, logic [3:0] l, logic i);
        vec_t v;
        v.name = name;
        v.n    = n;
        v.rst  = rst;
        v.bs   = bs;
        v.br   = br;
        v.col  = col;
        v.exp  = {s, h, o, r, l, i};
        return v;
    endfunction

    task automatic step(input logic rst, input logic bs, input logic br, input logic col);
        RESET       = rst;
        BTN_START   = bs;
        BTN_RESTART = br;
        COLLIDE     = col;
        @(posedge CLK);
        #1;
    endtask

    task automatic compare(input string name, input int cyc, input logic [8:0] exp);
        logic [8:0] got;
        got = {START, HURT, OVER, RESTART, LIVES_LEFT, INVULN};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s[%0d] {START,HURT,OVER,RESTART,LIVES_LEFT,INVULN} got %b required %b",
                     name, cyc, got, exp);
        end
    endtask

    initial begin
        logic [15:0] gpat;

        RESET       = 1'b1;
        BTN_START   = 1'b0;
        BTN_RESTART = 1'b0;
        COLLIDE     = 1'b0;

        //           name            n  rst bs br col  S  H  O  R  L  I
        tbl.push_back(mk("reset",        3, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("start_wait",   7, 0, 1, 0, 0,  0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("start_rise",   1, 0, 1, 0, 0,  1, 0, 0, 0, 3, 0));
        tbl.push_back(mk("start_hold",   2, 0, 1, 0, 0,  1, 0, 0, 0, 3, 0));
        tbl.push_back(mk("start_rel",    8, 0, 0, 0, 0,  1, 0, 0, 0, 3, 0));
        tbl.push_back(mk("hit1",         1, 0, 0, 0, 1,  1, 1, 0, 0, 2, 1));
        tbl.push_back(mk("hurt1",        3, 0, 0, 0, 0,  1, 1, 0, 0, 2, 1));
        tbl.push_back(mk("inv_col",      1, 0, 0, 0, 1,  1, 0, 0, 0, 2, 1));
        tbl.push_back(mk("inv1",        11, 0, 0, 0, 0,  1, 0, 0, 0, 2, 1));
        tbl.push_back(mk("inv_last_col", 1, 0, 0, 0, 1,  1, 0, 0, 0, 2, 0));
        tbl.push_back(mk("run2",         3, 0, 0, 0, 0,  1, 0, 0, 0, 2, 0));
        tbl.push_back(mk("run_restart", 10, 0, 0, 1, 0,  1, 0, 0, 0, 2, 0));
        tbl.push_back(mk("run_rrel",     8, 0, 0, 0, 0,  1, 0, 0, 0, 2, 0));
        tbl.push_back(mk("hit2",         1, 0, 0, 0, 1,  1, 1, 0, 0, 1, 1));
        tbl.push_back(mk("hurt2",        3, 0, 0, 0, 0,  1, 1, 0, 0, 1, 1));
        tbl.push_back(mk("inv2",        12, 0, 0, 0, 0,  1, 0, 0, 0, 1, 1));
        tbl.push_back(mk("run3",         3, 0, 0, 0, 0,  1, 0, 0, 0, 1, 0));
        tbl.push_back(mk("hit3_fatal",   1, 0, 0, 0, 1,  0, 0, 1, 0, 0, 0));
        tbl.push_back(mk("dead",         4, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0));
        tbl.push_back(mk("dead_start",  10, 0, 1, 0, 0,  0, 0, 1, 0, 0, 0));
        tbl.push_back(mk("dead_srel",    8, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0));
        tbl.push_back(mk("restart_wait", 7, 0, 0, 1, 0,  0, 0, 1, 0, 0, 0));
        tbl.push_back(mk("restart",      1, 0, 0, 1, 0,  0, 0, 0, 1, 0, 0));
        tbl.push_back(mk("idle_hold",    2, 0, 0, 1, 0,  0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("idle_rel",     8, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("idle_col",     1, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("idle",         2, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("start2_wait",  7, 0, 1, 0, 0,  0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("start2",       1, 0, 1, 0, 0,  1, 0, 0, 0, 3, 0));
        tbl.push_back(mk("start2_hold",  2, 0, 1, 0, 0,  1, 0, 0, 0, 3, 0));
        tbl.push_back(mk("start2_rel",   8, 0, 0, 0, 0,  1, 0, 0, 0, 3, 0));
        tbl.push_back(mk("hit4",         1, 0, 0, 0, 1,  1, 1, 0, 0, 2, 1));
        tbl.push_back(mk("hurt4",        1, 0, 0, 0, 0,  1, 1, 0, 0, 2, 1));
        tbl.push_back(mk("reset_mid",    1, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("post_rst_col", 1, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("post_rst",     4, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0));

        foreach (tbl[k]) begin
            for (int c = 0; c < tbl[k].n; c++) begin
                step(tbl[k].rst, tbl[k].bs, tbl[k].br, tbl[k].col);
                compare(tbl[k].name, c, tbl[k].exp);
            end
        end

        // Glitches of 3 synced cycles separated by one agreeing cycle never debounce.
        gpat = 16'h0077;
        for (int c = 0; c < 16; c++) begin
            step(1'b0, gpat[c], 1'b0, 1'b0);
            compare("glitch", c, 9'b0_0_0_0_0000_0);
        end

        // Exactly DEBOUNCE_CYCLES high samples is accepted; START follows 8 edges after first sample.
        for (int c = 0; c < 12; c++) begin
            step(1'b0, (c < 4) ? 1'b1 : 1'b0, 1'b0, 1'b0);
            compare("min_press", c, (c >= 7) ? 9'b1_0_0_0_0011_0 : 9'b0_0_0_0_0000_0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
